// File: rtl/unsigned_calc_solver_v.sv
// Exhaustive sequential inverse of f = KA*a - KB*b + KC*c (mod 2^W_OUT):
// scans every {a,b,c} one per cycle and reports the first triple that hits the target.
module unsigned_calc_solver_v #(
  parameter int unsigned W_IN  = 4,
  parameter int unsigned W_OUT = 8,
  parameter int unsigned KA    = 7,
  parameter int unsigned KB    = 3,
  parameter int unsigned KC    = 6
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [W_OUT-1:0] i_fu,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_found,
  output logic [W_IN-1:0]  o_au,
  output logic [W_IN-1:0]  o_bu,
  output logic [W_IN-1:0]  o_cu
);

  localparam int unsigned NW = 3 * W_IN;

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  state_t            state, state_nxt;
  logic [NW-1:0]     n, n_nxt;
  logic [W_OUT-1:0]  target, target_nxt;
  logic              found_nxt;
  logic [W_IN-1:0]   a_nxt, b_nxt, c_nxt;
  logic [W_IN-1:0]   cand_a, cand_b, cand_c;
  logic [W_OUT-1:0]  v;

  // Constant multiply as a sum of shifted copies; wraps at W_OUT bits.
  function automatic logic [W_OUT-1:0] mul_k(input logic [W_OUT-1:0] x,
                                             input int unsigned k);
    logic [W_OUT-1:0] acc;
    acc = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (k[i]) acc = acc + (x << i);
    end
    return acc;
  endfunction

  assign cand_a = n[NW-1 -: W_IN];
  assign cand_b = n[2*W_IN-1 -: W_IN];
  assign cand_c = n[W_IN-1:0];

  assign v = mul_k(W_OUT'(cand_a), KA) - mul_k(W_OUT'(cand_b), KB)
           + mul_k(W_OUT'(cand_c), KC);

  assign o_busy = (state != IDLE);
  assign o_done = (state == DONE);

  always_comb begin
    state_nxt  = state;
    n_nxt      = n;
    target_nxt = target;
    found_nxt  = o_found;
    a_nxt      = o_au;
    b_nxt      = o_bu;
    c_nxt      = o_cu;
    unique case (state)
      IDLE: begin
        if (i_start) begin
          target_nxt = i_fu;
          n_nxt      = '0;
          found_nxt  = 1'b0;
          a_nxt      = '0;
          b_nxt      = '0;
          c_nxt      = '0;
          state_nxt  = SEARCH;
        end
      end
      SEARCH: begin
        if (v == target) begin
          found_nxt = 1'b1;
          a_nxt     = cand_a;
          b_nxt     = cand_b;
          c_nxt     = cand_c;
          state_nxt = DONE;
        end else if (&n) begin
          found_nxt = 1'b0;
          state_nxt = DONE;
        end else begin
          n_nxt = n + 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      n       <= '0;
      target  <= '0;
      o_found <= 1'b0;
      o_au    <= '0;
      o_bu    <= '0;
      o_cu    <= '0;
    end else begin
      state   <= state_nxt;
      n       <= n_nxt;
      target  <= target_nxt;
      o_found <= found_nxt;
      o_au    <= a_nxt;
      o_bu    <= b_nxt;
      o_cu    <= c_nxt;
    end
  end

endmodule

// File: tb/tb_unsigned_calc_solver_v.sv
// Directed bench for unsigned_calc_solver_v: latency, first-match triples,
// reset abort, start handling and a strided target sweep against a brute-force model.
module tb_unsigned_calc_solver_v;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_start;
  logic [7:0] i_fu;
  logic       o_busy, o_done, o_found;
  logic [3:0] o_au, o_bu, o_cu;

  int checks   = 0;
  int failures = 0;

  unsigned_calc_solver_v #(.W_IN(4), .W_OUT(8), .KA(7), .KB(3), .KC(6)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_fu(i_fu),
    .o_busy(o_busy), .o_done(o_done), .o_found(o_found),
    .o_au(o_au), .o_bu(o_bu), .o_cu(o_cu)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Brute-force first match using plain integer arithmetic.
  task automatic model(input int t, output bit f, output int a, output int b,
                       output int c, output int idx);
    f = 0; a = 0; b = 0; c = 0; idx = 4095;
    for (int k = 0; k < 4096; k++) begin
      int ma, mb, mc;
      ma = k / 256; mb = (k / 16) % 16; mc = k % 16;
      if (!f && (((7*ma - 3*mb + 6*mc) % 256 + 256) % 256) == t) begin
        f = 1; a = ma; b = mb; c = mc; idx = k;
      end
    end
  endtask

  // Caller is at #1 after a posedge in IDLE; start is accepted at the next edge (cycle 0).
  task automatic run_search(input logic [7:0] t, input int exp_cyc, input bit exp_found,
                            input int ea, input int eb, input int ec);
    int cyc;
    bit seen;
    i_fu = t; i_start = 1'b1; cyc = 0; seen = 0;
    while (!seen && cyc < 5000) begin
      step();
      cyc++;
      if (cyc == 1) begin
        i_start = 1'b0;
        i_fu    = ~t;
      end
      if (o_done) seen = 1;
    end
    check($sformatf("done_seen_%02h", t), 32'(seen), 32'd1);
    check($sformatf("latency_%02h", t), 32'(cyc), 32'(exp_cyc));
    check($sformatf("found_%02h", t), 32'(o_found), 32'(exp_found));
    check($sformatf("a_%02h", t), 32'(o_au), 32'(ea));
    check($sformatf("b_%02h", t), 32'(o_bu), 32'(eb));
    check($sformatf("c_%02h", t), 32'(o_cu), 32'(ec));
    if (o_found) begin
      int f;
      f = ((7*int'(o_au) - 3*int'(o_bu) + 6*int'(o_cu)) % 256 + 256) % 256;
      check($sformatf("eqn_%02h", t), 32'(f), 32'(t));
    end
    step();
    check($sformatf("done_pulse_%02h", t), 32'(o_done), 32'd0);
    check($sformatf("idle_%02h", t), 32'(o_busy), 32'd0);
    check($sformatf("found_hold_%02h", t), 32'(o_found), 32'(exp_found));
  endtask

  initial begin
    bit mf;
    int ma, mb, mc, mi;
    bit seen;

    i_rst = 1'b1; i_start = 1'b0; i_fu = 8'h00;
    step(); step();
    check("rst_busy",  32'(o_busy),  32'd0);
    check("rst_done",  32'(o_done),  32'd0);
    check("rst_found", 32'(o_found), 32'd0);
    check("rst_a",     32'(o_au),    32'd0);
    check("rst_b",     32'(o_bu),    32'd0);
    check("rst_c",     32'(o_cu),    32'd0);
    i_rst = 1'b0;
    step();

    run_search(8'h00, 2,    1'b1, 0, 0, 0);
    run_search(8'h06, 3,    1'b1, 0, 0, 1);
    run_search(8'h07, 258,  1'b1, 1, 0, 0);
    run_search(8'hFF, 594,  1'b1, 2, 5, 0);
    run_search(8'hC8, 4097, 1'b0, 0, 0, 0);

    // Reset mid-search: abort with no done pulse.
    i_fu = 8'hFF; i_start = 1'b1;
    step();
    i_start = 1'b0;
    repeat (99) step();
    check("mid_busy", 32'(o_busy), 32'd1);
    i_rst = 1'b1;
    step();
    check("abort_busy",  32'(o_busy),  32'd0);
    check("abort_done",  32'(o_done),  32'd0);
    check("abort_found", 32'(o_found), 32'd0);
    check("abort_a",     32'(o_au),    32'd0);
    i_rst = 1'b0;
    seen = 0;
    repeat (20) begin
      step();
      if (o_done || o_busy) seen = 1;
    end
    check("abort_quiet", 32'(seen), 32'd0);

    // Start and target toggled mid-search must not disturb the 0x06 result.
    i_fu = 8'h06; i_start = 1'b1;
    step();
    i_fu = 8'h00; i_start = 1'b1;
    step();
    check("tog_done_c2", 32'(o_done), 32'd0);
    i_fu = 8'hFF; i_start = 1'b0;
    step();
    check("tog_done_c3", 32'(o_done),  32'd1);
    check("tog_found",   32'(o_found), 32'd1);
    check("tog_a",       32'(o_au),    32'd0);
    check("tog_b",       32'(o_bu),    32'd0);
    check("tog_c",       32'(o_cu),    32'd1);
    step();

    // Start held high: ignored in DONE, re-accepted on the following IDLE cycle.
    i_fu = 8'h00; i_start = 1'b1;
    step();
    step();
    check("hold_done_c2", 32'(o_done), 32'd1);
    step();
    check("hold_idle_c3", 32'(o_busy), 32'd0);
    step();
    check("hold_busy_c4", 32'(o_busy), 32'd1);
    check("hold_nodone_c4", 32'(o_done), 32'd0);
    step();
    check("hold_done_c5", 32'(o_done), 32'd1);
    i_start = 1'b0;
    step();

    // Strided sweep of targets against the brute-force model.
    for (int t = 0; t < 256; t += 13) begin
      model(t, mf, ma, mb, mc, mi);
      run_search(8'(t), mf ? mi + 2 : 4097, mf, ma, mb, mc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
